// File: rtl/freq_pkg.sv
// freq_pkg: shared encodings and default constants for freq_mode_ctrl.
//   mode_e  - divider mode selector (index into the divisor table)
//   state_e - mode-change FSM states
//   DEF_*   - default counter width and per-mode terminal counts
package freq_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned DEF_DIV0  = 12_000_000;
  localparam int unsigned DEF_DIV1  = 1000;
  localparam int unsigned DEF_DIV2  = 6_000_000;
  localparam int unsigned DEF_DIV3  = 100;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n - clock, async active-low reset (priority back to requester 0)
//   req[1:0]   - request vector
//   adv        - advance strobe: when high and a grant is given, the priority
//                moves to the requester that did not win
//   gnt[1:0]   - one-hot grant (combinational from req and priority)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  // prio = 0: requester 0 favoured; prio = 1: requester 1 favoured
  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (!prio) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   prio <= 1'b0;
    else if (adv && (gnt != 2'b00)) prio <= gnt[0];
  end

endmodule

// File: rtl/freq_mode_ctrl.sv
// freq_mode_ctrl: programmable clock-enable divider with arbitrated mode changes.
//   I_CLK, I_RST_N     - clock, async active-low reset
//   I_EN               - count enable (counter and O_CLK hold when low)
//   I_REQ[1:0]         - level mode-change requests, held until granted
//   I_MODE0, I_MODE1   - requested mode per requester
//   O_GNT[1:0]         - one-cycle grant when a requester's mode is applied
//   O_TICK             - high in the terminal-count cycle
//   O_CLK              - registered divided square wave, toggles on each tick
//   O_MODE             - mode currently in effect
//   O_BUSY             - a latched change is waiting to be applied
module freq_mode_ctrl
  import freq_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DIV0       = DEF_DIV0,
  parameter int unsigned DIV1       = DEF_DIV1,
  parameter int unsigned DIV2       = DEF_DIV2,
  parameter int unsigned DIV3       = DEF_DIV3,
  parameter mode_e       RESET_MODE = MODE0
) (
  input  logic       I_CLK,
  input  logic       I_RST_N,
  input  logic       I_EN,
  input  logic [1:0] I_REQ,
  input  logic [1:0] I_MODE0,
  input  logic [1:0] I_MODE1,
  output logic [1:0] O_GNT,
  output logic       O_TICK,
  output logic       O_CLK,
  output logic [1:0] O_MODE,
  output logic       O_BUSY
);

  state_e           state, state_nxt;
  mode_e            mode, pend_mode;
  logic             win;
  logic [1:0]       arb_gnt;
  logic             arb_adv;
  logic [CNT_W-1:0] cnt, div;
  logic             term, tick, apply;
  logic             clk_q;

  // Arbitration happens only when IDLE sees a request; that is also when
  // the winner gets latched, so the pointer moves exactly once per change.
  assign arb_adv = (state == ST_IDLE);

  rr_arb2 u_arb (
    .clk   (I_CLK),
    .rst_n (I_RST_N),
    .req   (I_REQ),
    .adv   (arb_adv),
    .gnt   (arb_gnt)
  );

  always_comb begin
    div = CNT_W'(DIV0);
    case (mode)
      MODE0:   div = CNT_W'(DIV0);
      MODE1:   div = CNT_W'(DIV1);
      MODE2:   div = CNT_W'(DIV2);
      MODE3:   div = CNT_W'(DIV3);
      default: div = CNT_W'(DIV0);
    endcase
  end

  assign term = (cnt == div);
  // Gated by reset so a zero divisor cannot show a tick while held in reset.
  assign tick = I_RST_N & I_EN & term;

  // A change lands only on a wrap, so each half-period sees one divisor.
  // Re-selecting the active mode needs no wrap: nothing actually changes.
  assign apply = (state == ST_PEND) && (tick || (pend_mode == mode));

  // FSM state register
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (I_REQ != 2'b00) state_nxt = ST_PEND;
      ST_PEND: if (apply)          state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    O_BUSY = (state == ST_PEND);
    O_GNT  = 2'b00;
    if (apply) O_GNT = win ? 2'b10 : 2'b01;
  end

  // Winner and its mode are captured on entry to PEND; later changes on
  // I_REQ / I_MODEx (including a dropped request) do not affect them.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      win       <= 1'b0;
      pend_mode <= RESET_MODE;
    end else if ((state == ST_IDLE) && (I_REQ != 2'b00)) begin
      win       <= arb_gnt[1];
      pend_mode <= arb_gnt[1] ? mode_e'(I_MODE1) : mode_e'(I_MODE0);
    end
  end

  // Divider datapath
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      cnt   <= '0;
      clk_q <= 1'b0;
    end else if (I_EN) begin
      if (term) begin
        cnt   <= '0;
        clk_q <= ~clk_q;
      end else begin
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N)   mode <= RESET_MODE;
    else if (apply) mode <= pend_mode;
  end

  assign O_TICK = tick;
  assign O_CLK  = clk_q;
  assign O_MODE = mode;

endmodule
